seg7_scan_ctrl: RTL and testbench

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_scan_ctrl.sv | 97 +++++++++
 tb/tb_seg7_scan_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Round-robin scan controller that time-shares one BCD-to-7-segment decoder.
// Each digit slot starts with a few dark cycles so the previous digit cannot ghost.
//
// slot  | meaning
// BLANK | presc < BLANK_CYC, all digit enables low
// SHOW  | presc >= BLANK_CYC, enable digit idx unless it is suppressed
module seg7_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int PRESCALE  = 1000,
  parameter int BLANK_CYC = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  lzs,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] data,
  output logic                  ready,
  output logic [3:0]            digit_code,
  output logic [N_DIGITS-1:0]   digit_en,
  output logic                  frame_start
);

  localparam int PW = $clog2(PRESCALE);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_MAX   = IW'(N_DIGITS - 1);
  localparam logic [0:0]    BLANK     = 1'b0;
  localparam logic [0:0]    SHOW      = 1'b1;

  logic [PW-1:0]         presc, presc_n;
  logic [IW-1:0]         idx, idx_n;
  logic [4*N_DIGITS-1:0] disp, disp_n, pend;
  logic                  run;
  logic                  boundary;
  logic [0:0]            slot_n;
  logic [3:0]            code_n;
  logic [N_DIGITS-1:0]   lead_zero, dark, en_n;

  // Outputs are registered from next-state values so they line up with presc/idx/disp.
  always_comb begin : step
    presc_n = presc;
    idx_n   = idx;
    if (!en || !run) begin
      presc_n = '0;
      idx_n   = '0;
    end else if (presc == PRESC_MAX) begin
      presc_n = '0;
      idx_n   = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end else begin
      presc_n = presc + 1'b1;
    end
    boundary = en && (presc_n == '0) && (idx_n == '0);
    disp_n   = (boundary && !ready) ? pend : disp;
    slot_n   = (presc_n < BLANK_END) ? BLANK : SHOW;
  end

  always_comb begin : suppress
    lead_zero = '0;
    dark      = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      lead_zero[i] = ((disp_n >> (4 * i)) == '0);
      dark[i]      = (disp_n[4*i +: 4] > 4'd9) || (lzs && (i != 0) && lead_zero[i]);
    end
    code_n = disp_n[{idx_n, 2'b00} +: 4];
    en_n   = '0;
    if (slot_n == SHOW && !dark[idx_n]) en_n[idx_n] = 1'b1;
  end

  // ready doubles as the inverted pending-valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      idx         <= '0;
      disp        <= '0;
      pend        <= '0;
      run         <= 1'b0;
      ready       <= 1'b1;
      digit_code  <= 4'd0;
      digit_en    <= '0;
      frame_start <= 1'b0;
    end else begin
      presc <= presc_n;
      idx   <= idx_n;
      disp  <= disp_n;
      run   <= en;
      if (load && ready) pend <= data;
      if (boundary && !ready)  ready <= 1'b1;
      else if (load && ready)  ready <= 1'b0;
      digit_code  <= code_n;
      digit_en    <= en_n;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed scenarios plus random traffic against a
// frame-position model (position = idx*PRESCALE + presc within a frame).
module tb_seg7_scan_ctrl;
  localparam int ND = 4;
  localparam int PS = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * PS;

  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, lzs = 1'b0, load = 1'b0;
  logic [4*ND-1:0] data = '0;
  logic ready, frame_start;
  logic [3:0] digit_code;
  logic [ND-1:0] digit_en;

  int total = 0, bad = 0;

  int pos;
  bit running, m_pendv, m_fs, m_lzs;
  logic [15:0] m_disp, m_pend;

  seg7_scan_ctrl #(.N_DIGITS(ND), .PRESCALE(PS), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .lzs(lzs), .load(load), .data(data),
    .ready(ready), .digit_code(digit_code), .digit_en(digit_en),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset;
    pos = 0; running = 0; m_pendv = 0; m_fs = 0; m_lzs = 0;
    m_disp = '0; m_pend = '0;
  endtask

  task automatic model_step(input bit e, input bit l, input bit lz, input logic [15:0] d);
    logic [15:0] old_pend;
    bit old_pendv;
    old_pend = m_pend;
    old_pendv = m_pendv;
    m_lzs = lz;
    if (!e) begin
      pos = 0; running = 0;
    end else if (!running) begin
      pos = 0; running = 1;
    end else begin
      pos = (pos + 1) % FRAME;
    end
    m_fs = e && (pos == 0);
    if (l && !old_pendv) begin
      m_pend = d; m_pendv = 1;
    end
    if (m_fs && old_pendv) begin
      m_disp = old_pend; m_pendv = 0;
    end
  endtask

  task automatic check_outputs;
    int idx, presc, digit;
    logic [15:0] above;
    bit blank;
    logic [31:0] exp_en;
    idx   = pos / PS;
    presc = pos % PS;
    above = m_disp >> (4 * idx);
    digit = int'(above & 16'hF);
    blank = (digit > 9) || (m_lzs && idx > 0 && above == 0);
    exp_en = (running && presc >= BC && !blank) ? (32'd1 << idx) : 32'd0;
    check("digit_code", 32'(digit_code), 32'(digit));
    check("digit_en", 32'(digit_en), exp_en);
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("ready", 32'(ready), 32'(!m_pendv));
    check("onehot", 32'($countones(digit_en) <= 1), 32'd1);
  endtask

  task automatic cycle;
    @(posedge clk);
    model_step(en, load, lzs, data);
    #1 check_outputs();
  endtask

  task automatic load_and_run(input logic [15:0] d, input int n);
    load = 1'b1; data = d;
    cycle();
    load = 1'b0;
    repeat (n) cycle();
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] r;
    int keep;
    r = '0;
    for (int i = 0; i < ND; i++)
      r[4*i +: 4] = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(0, 15));
    keep = $urandom_range(1, ND);
    if ($urandom_range(0, 2) == 0) r = r & 16'((32'd1 << (4 * keep)) - 1);
    return r;
  endfunction

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check("rst_code", 32'(digit_code), 32'd0);
    check("rst_en", 32'(digit_en), 32'd0);
    check("rst_fs", 32'(frame_start), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    en = 1'b1;
    #9 rst_n = 1'b1;

    // Load 1234 in cycle 3; displayed from the next frame.
    repeat (3) cycle();
    load_and_run(16'h1234, 40);
    // Second load while a transfer is pending is dropped.
    load_and_run(16'h9999, 3);
    load_and_run(16'h5555, 70);

    lzs = 1'b1;
    load_and_run(16'h0050, 70);
    load_and_run(16'h0000, 70);
    lzs = 1'b0;
    load_and_run(16'h1A34, 70);

    // Drop en in the middle of digit 2's SHOW phase.
    for (int k = 0; k < 2 * FRAME && pos != 2 * PS + 4; k++) cycle();
    check("reach_digit2", 32'(pos), 32'(2 * PS + 4));
    en = 1'b0;
    repeat (3) cycle();
    en = 1'b1;
    repeat (12) cycle();

    // Asynchronous reset mid-slot with a pending value.
    load_and_run(16'h4321, 5);
    #3 rst_n = 1'b0;
    #1;
    check("arst_code", 32'(digit_code), 32'd0);
    check("arst_en", 32'(digit_en), 32'd0);
    check("arst_fs", 32'(frame_start), 32'd0);
    check("arst_ready", 32'(ready), 32'd1);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (40) cycle();

    for (int n = 0; n < 3000; n++) begin
      if (en) en = ($urandom_range(0, 99) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      load = ($urandom_range(0, 19) == 0);
      data = rand_data();
      if ($urandom_range(0, 199) == 0) lzs = ~lzs;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
